fetch: RTL and testbench
========================

# fetch

Instruction-fetch stage of the rvga pipeline: owns the program counter, issues word requests to instruction memory over a request/grant/response handshake and buffers returned instructions in a small queue feeding decode. It is the consuming end of the branch-redirect path: it accepts the resolved jump target and redirect decision produced by execute, flushes wrong-path work and restarts fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- QDEPTH, 2, instruction queue entries (power of two, ≥2)
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  decode cannot accept; queue head held
- redirect_valid  in  1  execute resolved a taken branch/jump this cycle
- redirect_tgt  in  32  new PC; bits [1:0] ignored (treated as 0)
- imem_req  out  1  request valid
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid (in order, ≥1 cycle after gnt)
- imem_rdata  in  32  instruction word
- if_id_valid  out  1  queue head valid
- if_id_pc  out  32  PC of queue head
- if_id_instr  out  32  instruction of queue head

## Operation
- At most one imem request outstanding (granted, response pending).
- FSM: IDLE (none outstanding), WAIT (one outstanding, current path), DROP (one outstanding, stale).
- imem_req asserted in IDLE when occupancy < QDEPTH; also in WAIT/DROP in the cycle rvalid returns if space allows (back-to-back). imem_addr = fetch PC.
- Before gnt, imem_req/imem_addr may change only due to redirect; otherwise held stable.
- On gnt: fetch PC += 4 (wraps modulo 2^32); IDLE→WAIT.
- WAIT + rvalid: push {issued PC, rdata}; →IDLE (or stay WAIT if a new gnt same cycle).
- DROP + rvalid: data discarded, nothing pushed; →IDLE (or WAIT on same-cycle gnt).
- Pop when if_id_valid & ~stall.
- Push and pop same cycle allowed when full (pop frees slot).
- Redirect (highest priority): queue flushed, fetch PC = redirect_tgt & ~3, any same-cycle pop/push suppressed.
  - IDLE, or WAIT with same-cycle rvalid: →IDLE, request target next cycle.
  - WAIT without rvalid, or same-cycle gnt: →DROP.
  - DROP: stays DROP unless rvalid same cycle (→IDLE).
- Issued PC of the outstanding request kept in a register for the push.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, if_id_valid 0, if_id_pc RESET_PC, if_id_instr 0 (NOP encoding 32'h0000_0013 not required), FSM IDLE, queue empty.
- First imem_req in first cycle after rst_n deasserts.
- Latency: rvalid in cycle N → if_id_valid in N+1 (without bypass).
- Redirect in cycle N → if_id_valid 0 in N+1; imem_req with target no earlier than N+1.
- Reset asserted mid-transaction: all state cleared immediately; any later rvalid from the aborted request is undefined and must not occur (imem is reset together).

## Configuration
- RVGA_FETCH_BYPASS_EN defined: when queue empty, state WAIT, rvalid and no redirect, imem_rdata and issued PC drive if_id_* combinationally in cycle N; if ~stall the word is consumed and not pushed; if stall it is pushed. Fetch-to-decode latency 0.
- Undefined: no bypass path; outputs come only from queue storage; latency 1.

## Structure
- Shared package: fetch FSM state enum, NOP constant, word/address type (rvga_word), redirect bundle type (valid + target) for reuse in execute.
- One sub-module: fetch_queue (parameterised QDEPTH circular FIFO with push, pop, flush, full/empty, count); FSM and PC logic in fetch.

## Test plan
- Reset, gnt every cycle, rvalid one cycle after gnt, no stall → addresses 0x0,0x4,0x8…; if_id_pc 0x0,0x4,… one per cycle after fill.
- stall held 5 cycles → queue fills to 2, imem_req drops with none outstanding, head stays pc 0x0; release → ordered drain 0x0,0x4, fetch resumes at 0x8.
- Redirect to 0x100 while WAIT (gnt for 0x8 given, rvalid 3 cycles later) → stale word dropped, next if_id_pc 0x100, never 0x8.
- Redirect to 0x203 with same-cycle rvalid → data discarded, next request address 0x200, FSM IDLE.
- PC at 0xFFFF_FFFC, gnt → next address 0x0000_0000.
- RVGA_FETCH_BYPASS_EN on, empty queue, rvalid with rdata 0x00A00093 at pc 0x10 → if_id_valid/if_id_instr same cycle; same with stall → appears next cycle from queue.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared rvga fetch types: FSM state, word type, redirect bundle, NOP encoding.
package fetch_pkg;
  typedef logic [31:0] rvga_word;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_e;
  typedef struct packed {
    logic     valid;
    rvga_word tgt;
  } redirect_t;
  localparam rvga_word NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of {pc, instr} pairs with flush, full/empty and count.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int       DEPTH  = 2,
  parameter rvga_word RST_PC = 32'h0000_0000,
  localparam int      AW     = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     push,
  input  logic     pop,
  input  rvga_word push_pc,
  input  rvga_word push_instr,
  output rvga_word head_pc,
  output rvga_word head_instr,
  output logic     empty,
  output logic     full,
  output logic [AW:0] count
);
  rvga_word pc_q [DEPTH];
  rvga_word pc_d [DEPTH];
  rvga_word instr_q [DEPTH];
  rvga_word instr_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign count = cnt_q;
  assign head_pc = pc_q[rd_q];
  assign head_instr = instr_q[rd_q];
  always_comb begin
    do_push = push & ~flush & (~full | pop);
    do_pop = pop & ~empty & ~flush;
    pc_d = pc_q;
    instr_d = instr_q;
    if (do_push) begin
      pc_d[wr_q] = push_pc;
      instr_d[wr_q] = push_instr;
    end
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '{default: RST_PC};
      instr_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fetch.sv
// fetch: rvga PC and single-outstanding imem request FSM feeding a decode queue.
// Define RVGA_FETCH_BYPASS_EN for a zero-latency path from imem_rdata into if_id_* when the queue is empty.
module fetch
  import fetch_pkg::*;
#(
  parameter rvga_word RESET_PC = 32'h0000_0000,
  parameter int       QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_tgt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);
  localparam int CW = $clog2(QDEPTH) + 1;
  fetch_state_e state_q, state_d;
  rvga_word pc_q, pc_d, ipc_q, ipc_d, q_pc, q_instr;
  redirect_t rdr;
  logic gnt_ok, busy, good, byp, q_push, q_pop, q_empty, q_full;
  logic [CW-1:0] q_count;
  logic [CW:0] occ;
  assign rdr = '{valid: redirect_valid, tgt: redirect_tgt & ~32'h3};
  always_comb begin
    good = (state_q == WAIT) & imem_rvalid & ~rdr.valid;
`ifdef RVGA_FETCH_BYPASS_EN
    byp = good & q_empty;
`else
    byp = 1'b0;
`endif
    if_id_valid = ~q_empty | byp;
    if_id_pc = byp ? ipc_q : q_pc;
    if_id_instr = byp ? imem_rdata : q_instr;
    q_pop = ~q_empty & ~stall;
    q_push = good & (~q_full | q_pop) & ~(byp & ~stall);
    // Only request when the response is guaranteed a slot on arrival.
    occ = {1'b0, q_count} + (CW+1)'(q_push) - (CW+1)'(q_pop);
    imem_req = rst_n & ((state_q == IDLE) | imem_rvalid) & (occ < (CW+1)'(QDEPTH));
    imem_addr = pc_q;
    gnt_ok = imem_req & imem_gnt;
    busy = (state_q != IDLE) & ~imem_rvalid;
    state_d = (gnt_ok | busy) ? (rdr.valid ? DROP : (gnt_ok ? WAIT : state_q)) : IDLE;
    pc_d = rdr.valid ? rdr.tgt : (gnt_ok ? pc_q + 32'd4 : pc_q);
    ipc_d = gnt_ok ? pc_q : ipc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      ipc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ipc_q <= ipc_d;
    end
  end
  fetch_queue #(.DEPTH(QDEPTH), .RST_PC(RESET_PC)) u_queue (
    .clk(clk),
    .rst_n(rst_n),
    .flush(rdr.valid),
    .push(q_push),
    .pop(q_pop),
    .push_pc(ipc_q),
    .push_instr(imem_rdata),
    .head_pc(q_pc),
    .head_instr(q_instr),
    .empty(q_empty),
    .full(q_full),
    .count(q_count)
  );
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed fetch tests; a scoreboard queue of expected {pc, instr} is checked by a decode-side monitor.
module tb_fetch;
  import fetch_pkg::*;
  logic clk = 0, rst_n = 0, stall = 0, redirect_valid = 0;
  logic [31:0] redirect_tgt = '0;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic if_id_valid;
  logic [31:0] if_id_pc, if_id_instr;
  int checks = 0, errors = 0, lat = 1, left = 0;
  logic fire = 0, pend = 0;
  logic [31:0] faddr = '0, paddr = '0;
  logic [63:0] exp_q[$];

  fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_tgt(redirect_tgt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h10) ? 32'h00A0_0093 : a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, word(pc)});
  endtask

  task automatic reset_dut();
    step();
    rst_n = 0; stall = 0; redirect_valid = 0; imem_gnt = 0; lat = 1;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk(n, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // instruction memory: response lat cycles after the grant
  always begin
    @(negedge clk);
    fire = rst_n & imem_req & imem_gnt;
    faddr = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 0;
    if (!rst_n) pend = 0;
    else begin
      if (fire) begin
        pend = 1; paddr = faddr; left = lat;
      end
      if (pend) begin
        left--;
        if (left == 0) begin
          imem_rvalid = 1; imem_rdata = word(paddr); pend = 0;
        end
      end
    end
  end

  // decode-side monitor
  always @(negedge clk) begin
    if (rst_n && if_id_valid && !stall && !redirect_valid) begin
      if (exp_q.size() == 0) chk("unexpected_pop", if_id_pc, 32'hDEAD_BEEF);
      else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", if_id_pc, e[63:32]);
        chk("sb_instr", if_id_instr, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_pc", if_id_pc, 0);
    chk("rst_instr", if_id_instr, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    // streaming: grant every cycle, 1-cycle response
    reset_dut();
    for (int k = 0; k < 8; k++) expect_pc(32'(4 * k));
    imem_gnt = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_req", imem_req, 1);
      chk("t1_addr", imem_addr, 32'(4 * k));
      step();
    end
    imem_gnt = 0;
    drain("t1_drain");

    // stall fills the queue then releases
    reset_dut();
    expect_pc(0); expect_pc(4); expect_pc(8);
    stall = 1; imem_gnt = 1;
    step(); step(); step();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t2_req_off", imem_req, 0);
      chk("t2_valid", if_id_valid, 1);
      chk("t2_head", if_id_pc, 0);
      chk("t2_state", 32'(dut.state_q), 32'(IDLE));
      step();
    end
    stall = 0;
    @(negedge clk);
    chk("t2_resume_req", imem_req, 1);
    chk("t2_resume_addr", imem_addr, 32'h8);
    step();
    imem_gnt = 0;
    drain("t2_drain");

    // redirect while WAIT: stale word for 0x8 must be dropped
    reset_dut();
    expect_pc(0); expect_pc(4); expect_pc(32'h100);
    imem_gnt = 1;
    step(); step();
    @(negedge clk);
    lat = 3;
    step();
    imem_gnt = 0;
    step();
    redirect_valid = 1; redirect_tgt = 32'h100; imem_gnt = 1;
    @(negedge clk);
    lat = 1;
    step();
    redirect_valid = 0;
    @(negedge clk);
    chk("t3_state", 32'(dut.state_q), 32'(DROP));
    chk("t3_valid", if_id_valid, 0);
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 32'h100);
    step();
    imem_gnt = 0;
    drain("t3_drain");

    // redirect to 0x203 coinciding with rvalid
    reset_dut();
    expect_pc(32'h200);
    imem_gnt = 1;
    step();
    imem_gnt = 0; redirect_valid = 1; redirect_tgt = 32'h203;
    step();
    redirect_valid = 0; imem_gnt = 1;
    @(negedge clk);
    chk("t4_state", 32'(dut.state_q), 32'(IDLE));
    chk("t4_valid", if_id_valid, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h200);
    step();
    imem_gnt = 0;
    drain("t4_drain");

    // PC wrap at the top of the address space
    reset_dut();
    expect_pc(32'hFFFF_FFFC); expect_pc(0);
    redirect_valid = 1; redirect_tgt = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0; imem_gnt = 1;
    @(negedge clk);
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    chk("t5_req_wrap", imem_req, 1);
    chk("t5_addr_wrap", imem_addr, 0);
    step();
    imem_gnt = 0;
    drain("t5_drain");

    // fetch-to-decode latency, with and without stall
    reset_dut();
    expect_pc(32'h10); expect_pc(32'h10);
    redirect_valid = 1; redirect_tgt = 32'h10;
    step();
    redirect_valid = 0; imem_gnt = 1;
    step();
    imem_gnt = 0;
    @(negedge clk);
`ifdef RVGA_FETCH_BYPASS_EN
    chk("t6_byp_valid", if_id_valid, 1);
    chk("t6_byp_pc", if_id_pc, 32'h10);
    chk("t6_byp_instr", if_id_instr, 32'h00A0_0093);
    step();
    @(negedge clk);
    chk("t6_byp_consumed", if_id_valid, 0);
`else
    chk("t6_lat_valid0", if_id_valid, 0);
    step();
    @(negedge clk);
    chk("t6_lat_valid1", if_id_valid, 1);
    chk("t6_lat_instr", if_id_instr, 32'h00A0_0093);
`endif
    step();
    redirect_valid = 1; redirect_tgt = 32'h10;
    step();
    redirect_valid = 0; imem_gnt = 1;
    step();
    imem_gnt = 0; stall = 1;
    @(negedge clk);
`ifdef RVGA_FETCH_BYPASS_EN
    chk("t6_stall_byp_valid", if_id_valid, 1);
`else
    chk("t6_stall_valid0", if_id_valid, 0);
`endif
    step();
    stall = 0;
    @(negedge clk);
    chk("t6_q_valid", if_id_valid, 1);
    chk("t6_q_pc", if_id_pc, 32'h10);
    chk("t6_q_instr", if_id_instr, 32'h00A0_0093);
    step();
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
